// File: rtl/count_snapshot_reader_if.sv
// Bundle of request, counter and byte-stream handshake signals for the
// counter snapshot reader. The master side is the reader itself.
interface count_snapshot_reader_if #(
  parameter int WIDTH = 64
);
  logic             req;
  logic             slt;
  logic [WIDTH-1:0] count0;
  logic [WIDTH-1:0] count1;
  logic [7:0]       data_out;
  logic             valid;
  logic             ready;
  logic             last;
  logic             busy;
  logic             done;

  modport master (
    input  req, slt, count0, count1, ready,
    output data_out, valid, last, busy, done
  );

  modport slave (
    output req, slt, count0, count1, ready,
    input  data_out, valid, last, busy, done
  );
endinterface

// File: rtl/count_snapshot_reader.sv
// Snapshots one of two counters on request and streams it out as a framed
// byte packet: header, NBYTES data bytes LSB-first, XOR checksum.
// All outputs are registered; they are computed from the next state so
// Valid rises in the cycle right after the accepting Req edge.
module count_snapshot_reader #(
  parameter int         WIDTH    = 64,
  parameter logic [7:0] HDR_BASE = 8'hA0
) (
  input  logic                           clk,
  input  logic                           rst,
  count_snapshot_reader_if.master        bus
);

  localparam int NBYTES = WIDTH / 8;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] snap_reg, snap_next;
  logic             sel_reg, sel_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic [7:0]       csum_reg, csum_next;

  logic [7:0]       data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             last_reg, last_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic             beat;
  logic [7:0]       snap_bytes [NBYTES];

  assign beat = valid_reg & bus.ready;

  // Byte view of the next snapshot, used to pick the byte presented next.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_bytes
      assign snap_bytes[gi] = snap_next[8*gi +: 8];
    end
  endgenerate

  // Next-state and datapath register updates.
  always_comb begin
    state_next = state_reg;
    snap_next  = snap_reg;
    sel_next   = sel_reg;
    idx_next   = idx_reg;
    csum_next  = csum_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req) begin
          snap_next  = bus.slt ? bus.count1 : bus.count0;
          sel_next   = bus.slt;
          idx_next   = '0;
          csum_next  = HDR_BASE | {7'b0, bus.slt};
          state_next = HDR;
        end
      end
      HDR: begin
        if (beat) begin
          idx_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (beat) begin
          csum_next = csum_reg ^ data_reg;
          idx_next  = idx_reg + 1'b1;
          if (idx_reg == LAST_IDX) state_next = CSUM;
        end
      end
      CSUM: begin
        if (beat) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered outputs derived from where the FSM is going next.
  always_comb begin
    data_next  = 8'h00;
    valid_next = 1'b0;
    last_next  = 1'b0;
    done_next  = 1'b0;
    busy_next  = (state_next != IDLE);
    case (state_next)
      HDR: begin
        data_next  = HDR_BASE | {7'b0, sel_next};
        valid_next = 1'b1;
      end
      DATA: begin
        data_next  = snap_bytes[idx_next];
        valid_next = 1'b1;
      end
      CSUM: begin
        data_next  = csum_next;
        valid_next = 1'b1;
        last_next  = 1'b1;
      end
      DONE: begin
        done_next = 1'b1;
      end
      default: begin
        data_next = 8'h00;
      end
    endcase
  end

  // State, snapshot and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      snap_reg  <= '0;
      sel_reg   <= 1'b0;
      idx_reg   <= '0;
      csum_reg  <= 8'h00;
      data_reg  <= 8'h00;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      snap_reg  <= snap_next;
      sel_reg   <= sel_next;
      idx_reg   <= idx_next;
      csum_reg  <= csum_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign bus.data_out = data_reg;
  assign bus.valid    = valid_reg;
  assign bus.last     = last_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;

endmodule
